// File: rtl/flag_unit.sv
// ALU producer for the branch-condition path: two-stage valid/ready pipeline
// (S1 operand latch, S2 result buffer) that owns the architectural NZCV register.
module flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             flags_busy
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ADC = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_sf_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q;
  logic             n_q, z_q, c_q, v_q;

  logic             accept, advance, commit;
  logic [WIDTH-1:0] b_op, logic_res, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, is_arith, is_sub;
  logic             n_d, z_d, c_d, v_d;

  assign advance  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;
  assign commit   = advance && (s1_sf_q || s1_op_q == OP_CMP);

  assign out_valid  = s2_valid_q;
  assign result     = result_q;
  assign n          = n_q;
  assign z          = z_q;
  assign c          = c_q;
  assign v          = v_q;
  assign flags_busy = s1_valid_q && (s1_sf_q || s1_op_q == OP_CMP);

  // ADC/SBC read the committed carry: any earlier flag-setting op has already
  // committed by the time this op is the one in S1.
  always_comb begin
    b_op      = s1_b_q;
    cin       = 1'b0;
    is_arith  = 1'b1;
    is_sub    = 1'b0;
    logic_res = '0;
    case (s1_op_q)
      OP_ADD: begin b_op = s1_b_q;  cin = 1'b0; end
      OP_SUB: begin b_op = ~s1_b_q; cin = 1'b1; is_sub = 1'b1; end
      OP_ADC: begin b_op = s1_b_q;  cin = c_q;  end
      OP_SBC: begin b_op = ~s1_b_q; cin = c_q;  is_sub = 1'b1; end
      OP_CMP: begin b_op = ~s1_b_q; cin = 1'b1; is_sub = 1'b1; end
      OP_AND: begin is_arith = 1'b0; logic_res = s1_a_q & s1_b_q; end
      OP_OR:  begin is_arith = 1'b0; logic_res = s1_a_q | s1_b_q; end
      OP_XOR: begin is_arith = 1'b0; logic_res = s1_a_q ^ s1_b_q; end
      default: begin is_arith = 1'b0; logic_res = '0; end
    endcase
    sum     = {1'b0, s1_a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;
  end

  always_comb begin
    n_d = alu_res[WIDTH-1];
    z_d = (alu_res == '0);
    c_d = c_q;
    v_d = v_q;
    if (is_arith) begin
      c_d = sum[WIDTH];
      if (is_sub)
        v_d = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
      else
        v_d = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)
      s1_valid_d = 1'b1;
    else if (advance)
      s1_valid_d = 1'b0;
    s2_valid_d = s2_valid_q;
    if (advance)
      s2_valid_d = 1'b1;
    else if (s2_valid_q && out_ready)
      s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (advance)
        result_q <= alu_res;
      if (commit) begin
        n_q <= n_d;
        z_q <= z_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end
  end

  // Operand registers carry no reset: they are only meaningful while s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q <= op_e'(op);
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_sf_q <= set_flags;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Table-driven bench for flag_unit with an in-order scoreboard of result/NZCV.
module tb_flag_unit;

  localparam int W = 32;

  logic         clk, reset;
  logic         in_valid, in_ready, set_flags, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         n, z, c, v, flags_busy;

  flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .n(n), .z(z), .c(c), .v(v), .flags_busy(flags_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } exp_t;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ADC = 3'b010, SBC = 3'b011;
  localparam logic [2:0] AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, CMP = 3'b111;

  vec_t tbl[15];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pops = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic sf, input logic [W-1:0] er, input logic [3:0] en,
                      output int waited);
    exp_t e;
    op = o; a = xa; b = xb; set_flags = sf; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) break;
    end
    if (waited > 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.res = er; e.nzcv = en;
      sb.push_back(e);
      #1 in_valid = 1'b0;
      $display("issue op=%0d a=%h b=%h sf=%b exp=%h nzcv=%b", o, xa, xb, sf, er, en);
    end
  endtask

  initial begin
    int waited, busy_cnt, pops0, guard;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; set_flags = 1'b0;

    tbl[0]  = '{ADD,  32'h1,        32'h1,        1'b1, 32'h2,        4'b0000};
    tbl[1]  = '{CMP,  32'h1,        32'h1,        1'b0, 32'h0,        4'b0110};
    tbl[2]  = '{CMP,  32'h0,        32'h1,        1'b0, 32'hFFFFFFFF, 4'b1000};
    tbl[3]  = '{ADD,  32'h7FFFFFFF, 32'h1,        1'b1, 32'h80000000, 4'b1001};
    tbl[4]  = '{ADD,  32'hFFFFFFFF, 32'h1,        1'b1, 32'h0,        4'b0110};
    tbl[5]  = '{CMP,  32'h5,        32'h3,        1'b0, 32'h2,        4'b0010};
    tbl[6]  = '{ADC,  32'h2,        32'h3,        1'b0, 32'h6,        4'b0010};
    tbl[7]  = '{XOR_, 32'hA5,       32'hA5,       1'b1, 32'h0,        4'b0110};
    tbl[8]  = '{SUB,  32'h3,        32'h5,        1'b1, 32'hFFFFFFFE, 4'b1000};
    tbl[9]  = '{SBC,  32'hA,        32'h3,        1'b1, 32'h6,        4'b0010};
    tbl[10] = '{AND_, 32'hF0F0,     32'h0FF0,     1'b1, 32'h00F0,     4'b0010};
    tbl[11] = '{OR_,  32'h80000000, 32'h1,        1'b1, 32'h80000001, 4'b1010};
    tbl[12] = '{SUB,  32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 4'b0011};
    tbl[13] = '{ADC,  32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        4'b0110};
    tbl[14] = '{ADD,  32'h5,        32'h5,        1'b0, 32'hA,        4'b0110};

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got result %h, required no output", result);
          end else begin
            e = sb.pop_front();
            pops++;
            chk("result", result, e.res);
            chk("nzcv", {28'h0, n, z, c, v}, {28'h0, e.nzcv});
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_nzcv", {28'h0, n, z, c, v}, 32'h0);
    chk("rst_busy", {31'h0, flags_busy}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;

    // Isolated ops: immediate acceptance, busy window width.
    send(ADD, 32'h1, 32'h1, 1'b1, 32'h2, 4'b0000, waited);
    chk("t1_accept_wait", waited, 32'h0);
    busy_cnt = 0;
    repeat (4) begin @(negedge clk); busy_cnt += flags_busy; end
    chk("t1_busy_cycles", busy_cnt, 32'h1);
    @(posedge clk); #1;
    send(CMP, 32'h1, 32'h1, 1'b0, 32'h0, 4'b0110, waited);
    busy_cnt = 0;
    repeat (4) begin @(negedge clk); busy_cnt += flags_busy; end
    chk("t2_cmp_busy_cycles", busy_cnt, 32'h1);
    @(posedge clk); #1;
    send(ADD, 32'h2, 32'h2, 1'b0, 32'h4, 4'b0110, waited);
    busy_cnt = 0;
    repeat (4) begin @(negedge clk); busy_cnt += flags_busy; end
    chk("t2_noflag_busy_cycles", busy_cnt, 32'h0);
    @(posedge clk); #1;

    // Flags reset to a known state via the table's first entry onward.
    send(AND_, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0110, waited);
    send(CMP, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0110, waited);
    send(ADD, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0100, waited);
    send(SUB, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0110, waited);
    send(AND_, 32'h1, 32'h0, 1'b1, 32'h0, 4'b0110, waited);
    send(ADD, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0100, waited);
    send(OR_, 32'h1, 32'h0, 1'b1, 32'h1, 4'b0000, waited);

    for (int i = 0; i < 15; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].res, tbl[i].nzcv, waited);
    repeat (3) @(posedge clk); #1;

    // Backpressure: two ops fill the pipe, the third waits.
    out_ready = 1'b0;
    send(ADD, 32'h1, 32'h2, 1'b1, 32'h3, 4'b0000, waited);
    send(SUB, 32'h9, 32'h4, 1'b1, 32'h5, 4'b0010, waited);
    chk("bp_second_accept_wait", waited, 32'h0);
    op = XOR_; a = 32'h0F; b = 32'hF0; set_flags = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
      chk("bp_result_stable", result, 32'h3);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    pops0 = pops;
    @(negedge clk);
    chk("bp_in_ready_release", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    begin
      exp_t e;
      e.res = 32'hFF; e.nzcv = 4'b0010;
      sb.push_back(e);
    end
    #1 in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("bp_drain_rate", pops - pops0, 32'h3);
    repeat (2) @(posedge clk); #1;

    // Reset with both stages full.
    out_ready = 1'b0;
    send(SUB, 32'h1, 32'h2, 1'b1, 32'hFFFFFFFF, 4'b1000, waited);
    send(CMP, 32'h2, 32'h7, 1'b0, 32'hFFFFFFFB, 4'b1000, waited);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_nzcv", {28'h0, n, z, c, v}, 32'h0);
    chk("mid_rst_busy", {31'h0, flags_busy}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    send(ADD, 32'h1, 32'h1, 1'b1, 32'h2, 4'b0000, waited);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin @(posedge clk); guard++; end
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
